// File: rtl/ysyx_23060184_axi_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_axi_rr_arbiter_if
// Brief    : Request/response/grant bundle between masters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_23060184_axi_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] req_wr;
  logic                   s_rvalid;
  logic                   m_rready;
  logic                   s_bvalid;
  logic                   m_bready;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDW-1:0]         grant_id;
  logic                   grant_wr;
  logic                   busy;
  logic                   timeout;

  modport slave (
    input  req, req_wr, s_rvalid, m_rready, s_bvalid, m_bready,
    output grant, grant_id, grant_wr, busy, timeout
  );

  modport master (
    output req, req_wr, s_rvalid, m_rready, s_bvalid, m_bready,
    input  grant, grant_id, grant_wr, busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060184_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_axi_rr_arbiter
// Brief    : N-master AXI4-Lite arbiter, round-robin or fixed priority,
//            grant held until response handshake, optional watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_axi_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MODE        = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  ysyx_23060184_axi_rr_arbiter_if.slave  bus
);

  localparam int             IDW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [1:0]     S_IDLE    = 2'd0;
  localparam logic [1:0]     S_GRANT_R = 2'd1;
  localparam logic [1:0]     S_GRANT_W = 2'd2;
  localparam logic [15:0]    TO_LAST  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_MASTERS - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [IDW-1:0]         last_q, last_d;
  logic                   wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [IDW-1:0]         winner;
  logic                   any_req;
  logic                   done;
  logic                   to_fire;

  // Round-robin scans from last+1 with wrap; fixed priority scans from 0.
  function automatic logic [IDW-1:0] pick_winner(
    input logic [NUM_MASTERS-1:0] r,
    input logic [IDW-1:0]         last
  );
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (MODE == 1) idx = i - 1;
      else           idx = (int'(last) + i) % NUM_MASTERS;
      if (!found && r[IDW'(idx)]) begin
        found = 1'b1;
        w     = IDW'(idx);
      end
    end
    return w;
  endfunction

  assign winner  = pick_winner(bus.req, last_q);
  assign any_req = |bus.req;
  assign done    = ((state_q == S_GRANT_R) && bus.s_rvalid && bus.m_rready) ||
                   ((state_q == S_GRANT_W) && bus.s_bvalid && bus.m_bready);
  // A completion on the expiry edge takes precedence over the watchdog.
  assign to_fire = (TIMEOUT != 0) && (state_q != S_IDLE) && (cnt_q == TO_LAST) && !done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= LAST_RST;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = bus.req_wr[winner] ? S_GRANT_W : S_GRANT_R;
      end
      S_GRANT_R, S_GRANT_W: begin
        if (done || to_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (any_req) begin
        grant_d         = '0;
        grant_d[winner] = 1'b1;
        id_d            = winner;
        wr_d            = bus.req_wr[winner];
        busy_d          = 1'b1;
        cnt_d           = 16'd0;
      end
    end else if (done || to_fire) begin
      grant_d = '0;
      busy_d  = 1'b0;
      wr_d    = 1'b0;
      last_d  = id_q;
      to_d    = to_fire;
      cnt_d   = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.grant_wr = wr_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = to_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_axi_rr_arbiter
// Brief    : Directed bench over four arbiter configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_axi_rr_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060184_axi_rr_arbiter_if #(.NUM_MASTERS(2)) ifa ();
  ysyx_23060184_axi_rr_arbiter_if #(.NUM_MASTERS(4)) ifb ();
  ysyx_23060184_axi_rr_arbiter_if #(.NUM_MASTERS(3)) ifc ();
  ysyx_23060184_axi_rr_arbiter_if #(.NUM_MASTERS(2)) ifd ();

  ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(2), .MODE(0), .TIMEOUT(0)) u_a (.clk(clk), .rstn(rstn), .bus(ifa));
  ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(4), .MODE(0), .TIMEOUT(0)) u_b (.clk(clk), .rstn(rstn), .bus(ifb));
  ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(3), .MODE(1), .TIMEOUT(0)) u_c (.clk(clk), .rstn(rstn), .bus(ifc));
  ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(2), .MODE(0), .TIMEOUT(8)) u_d (.clk(clk), .rstn(rstn), .bus(ifd));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_all();
    ifa.req = '0; ifa.req_wr = '0; ifa.s_rvalid = 0; ifa.m_rready = 0; ifa.s_bvalid = 0; ifa.m_bready = 0;
    ifb.req = '0; ifb.req_wr = '0; ifb.s_rvalid = 0; ifb.m_rready = 0; ifb.s_bvalid = 0; ifb.m_bready = 0;
    ifc.req = '0; ifc.req_wr = '0; ifc.s_rvalid = 0; ifc.m_rready = 0; ifc.s_bvalid = 0; ifc.m_bready = 0;
    ifd.req = '0; ifd.req_wr = '0; ifd.s_rvalid = 0; ifd.m_rready = 0; ifd.s_bvalid = 0; ifd.m_bready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    clr_all();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(ifa.grant), 32'h0);
    chk("rst_id",    32'(ifa.grant_id), 32'h0);
    chk("rst_wr",    32'(ifa.grant_wr), 32'h0);
    chk("rst_busy",  32'(ifa.busy), 32'h0);
    chk("rst_to",    32'(ifd.timeout), 32'h0);
    chk("rst_grant_b", 32'(ifb.grant), 32'h0);

    // Single read on A: grant cycles 1..3, handshake at edge 4.
    rstn    = 1'b1;
    ifa.req = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rd_grant", 32'(ifa.grant), 32'h1);
      if (c == 1) begin
        chk("rd_busy", 32'(ifa.busy), 32'h1);
        chk("rd_id",   32'(ifa.grant_id), 32'h0);
        chk("rd_wr",   32'(ifa.grant_wr), 32'h0);
      end
      if (c == 3) begin ifa.s_rvalid = 1; ifa.m_rready = 1; end
    end
    @(negedge clk);
    chk("rd_release", 32'(ifa.grant), 32'h0);
    chk("rd_idle_busy", 32'(ifa.busy), 32'h0);
    chk("rd_id_hold", 32'(ifa.grant_id), 32'h0);
    ifa.req = '0; ifa.s_rvalid = 0; ifa.m_rready = 0;

    // Type isolation on A: write granted, read pulse ignored.
    @(negedge clk);
    ifa.req = 2'b10; ifa.req_wr = 2'b10;
    @(negedge clk);
    chk("wr_grant", 32'(ifa.grant), 32'h2);
    chk("wr_id",    32'(ifa.grant_id), 32'h1);
    chk("wr_type",  32'(ifa.grant_wr), 32'h1);
    ifa.s_rvalid = 1; ifa.m_rready = 1;
    @(negedge clk);
    ifa.s_rvalid = 0; ifa.m_rready = 0; ifa.req_wr = 2'b00;
    for (int j = 0; j < 5; j++) begin
      chk("wr_hold", 32'(ifa.grant), 32'h2);
      chk("wr_type_hold", 32'(ifa.grant_wr), 32'h1);
      if (j < 4) @(negedge clk);
    end
    ifa.s_bvalid = 1; ifa.m_bready = 1;
    @(negedge clk);
    chk("wr_release", 32'(ifa.grant), 32'h0);
    chk("wr_rel_busy", 32'(ifa.busy), 32'h0);
    ifa.req = '0; ifa.s_bvalid = 0; ifa.m_bready = 0;

    // Round-robin on B: 0,1,2,3,0 with one idle cycle each.
    @(negedge clk);
    ifb.req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("rr_grant", 32'(ifb.grant), 32'(1 << (g % 4)));
      chk("rr_id",    32'(ifb.grant_id), 32'(g % 4));
      @(negedge clk);
      ifb.s_rvalid = 1; ifb.m_rready = 1;
      @(negedge clk);
      chk("rr_idle", 32'(ifb.grant), 32'h0);
      ifb.s_rvalid = 0; ifb.m_rready = 0;
      if (g == 4) ifb.req = '0;
    end

    // Fixed priority on C: master 1 keeps grant, then master 0 beats 2.
    @(negedge clk);
    ifc.req = 3'b110;
    @(negedge clk);
    chk("fp_first", 32'(ifc.grant), 32'h2);
    ifc.req = 3'b111;
    repeat (3) begin
      @(negedge clk);
      chk("fp_hold", 32'(ifc.grant), 32'h2);
    end
    ifc.s_rvalid = 1; ifc.m_rready = 1;
    @(negedge clk);
    chk("fp_release", 32'(ifc.grant), 32'h0);
    ifc.s_rvalid = 0; ifc.m_rready = 0;
    @(negedge clk);
    chk("fp_next", 32'(ifc.grant), 32'h1);
    chk("fp_next_id", 32'(ifc.grant_id), 32'h0);
    ifc.req = '0; ifc.s_rvalid = 1; ifc.m_rready = 1;
    @(negedge clk);
    chk("fp_done", 32'(ifc.grant), 32'h0);
    ifc.s_rvalid = 0; ifc.m_rready = 0;

    // Watchdog on D: release 8 cycles after grant, one-cycle pulse.
    ifd.req = 2'b01;
    @(negedge clk);
    chk("wd_grant", 32'(ifd.grant), 32'h1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk("wd_hold", 32'(ifd.grant), 32'h1);
      chk("wd_no_to", 32'(ifd.timeout), 32'h0);
    end
    @(negedge clk);
    chk("wd_drop", 32'(ifd.grant), 32'h0);
    chk("wd_pulse", 32'(ifd.timeout), 32'h1);
    chk("wd_busy", 32'(ifd.busy), 32'h0);
    ifd.req = 2'b11;
    @(negedge clk);
    chk("wd_pulse_end", 32'(ifd.timeout), 32'h0);
    chk("wd_last_adv", 32'(ifd.grant), 32'h2);
    chk("wd_last_id", 32'(ifd.grant_id), 32'h1);
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      chk("wd2_hold", 32'(ifd.grant), 32'h2);
      if (j == 7) begin ifd.s_rvalid = 1; ifd.m_rready = 1; ifd.req = '0; end
    end
    @(negedge clk);
    chk("wd2_release", 32'(ifd.grant), 32'h0);
    chk("wd2_no_pulse", 32'(ifd.timeout), 32'h0);
    ifd.s_rvalid = 0; ifd.m_rready = 0;
    @(negedge clk);
    chk("wd2_no_pulse_late", 32'(ifd.timeout), 32'h0);

    // Async reset on A while master 1 holds the grant and last=0.
    ifa.req = 2'b11; ifa.req_wr = 2'b00;
    @(negedge clk);
    chk("ar_pre0", 32'(ifa.grant), 32'h1);
    ifa.s_rvalid = 1; ifa.m_rready = 1;
    @(negedge clk);
    chk("ar_pre0_rel", 32'(ifa.grant), 32'h0);
    ifa.s_rvalid = 0; ifa.m_rready = 0;
    @(negedge clk);
    chk("ar_pre1", 32'(ifa.grant), 32'h2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_grant", 32'(ifa.grant), 32'h0);
    chk("ar_id",    32'(ifa.grant_id), 32'h0);
    chk("ar_busy",  32'(ifa.busy), 32'h0);
    chk("ar_wr",    32'(ifa.grant_wr), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("ar_first", 32'(ifa.grant), 32'h1);
    chk("ar_first_id", 32'(ifa.grant_id), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060184_axi_rr_arbiter.md
# ysyx_23060184_axi_rr_arbiter

Parametrised N-master arbiter that grants one AXI4-Lite master at a time exclusive access to the shared SRAM/UART slave path. It extends the current 2-master IFU/MEMU arbitration in three ways: a configurable master count, a round-robin or fixed-priority mode, and a per-transaction watchdog. The grant is held from request acceptance until the slave's read or write response handshake completes. It sits between the fetch/memory units and the SRAM/UART interconnect, and drives the same one-hot `grant` bus that the slave muxes consume.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesters; legal range 2..8.
- `MODE`, default 0: 0 = round-robin; 1 = fixed priority, where the lowest index wins.
- `TIMEOUT`, default 0: maximum number of cycles a grant may be held; 0 disables the watchdog; legal range 0..65535.

Ports:
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `rstn`  in  1  — reset, asynchronous and active-low.
- `req`  in  NUM_MASTERS  — per-master request level; held until the master's transaction completes.
- `req_wr`  in  NUM_MASTERS  — per-master transaction type; 1 = write, 0 = read. Valid while the matching `req` bit is high.
- `s_rvalid`  in  1  — slave read-data valid.
- `m_rready`  in  1  — read-data ready of the granted master, muxed externally.
- `s_bvalid`  in  1  — slave write-response valid.
- `m_bready`  in  1  — write-response ready of the granted master, muxed externally.
- `grant`  out  NUM_MASTERS  — one-hot grant, or all zero when idle.
- `grant_id`  out  max(1,clog2(NUM_MASTERS))  — binary index of the granted master; holds its last value when idle.
- `grant_wr`  out  1  — type of the granted transaction (1 = write).
- `busy`  out  1  — high while any grant is active.
- `timeout`  out  1  — one-cycle pulse when the watchdog forces a grant release.

## Operation
- States:
  - IDLE: no grant active.
  - GRANT_R: a read transaction is granted.
  - GRANT_W: a write transaction is granted.
- IDLE transitions:
  - If any `req` bit is high at a rising edge, select a winner and register `grant`, `grant_id`, `busy`=1 and `grant_wr`=`req_wr[winner]`.
  - Next state is GRANT_W if `req_wr[winner]`=1, otherwise GRANT_R.
- Winner selection:
  - MODE 0: search starts at index `last+1` and wraps modulo NUM_MASTERS. `last` is the index of the most recent grant; its reset value is NUM_MASTERS-1, so master 0 has first priority after reset.
  - MODE 1: the lowest set `req` index wins; `last` is ignored.
- Transaction completion:
  - GRANT_R completes on the first edge where `s_rvalid & m_rready` is high.
  - GRANT_W completes on the first edge where `s_bvalid & m_bready` is high.
  - On completion, `grant` is cleared, `busy` is cleared, `last` is updated to the completed master's index, and the state returns to IDLE.
- The type is fixed at grant time. Changes to `req_wr` or `req` during a grant are ignored; a master that drops `req` early does not release its grant.
- A response handshake of the wrong type has no effect: `s_bvalid` is ignored in GRANT_R and `s_rvalid` is ignored in GRANT_W.
- Watchdog (TIMEOUT>0):
  - A 16-bit counter clears on grant and increments every cycle while a grant is held.
  - When the counter reaches TIMEOUT-1 without completion, the next edge releases the grant exactly as a completion does, `last` is updated, and `timeout` pulses high for one cycle.
  - If completion and timeout occur on the same edge, completion wins and there is no pulse.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `grant_wr`=0, `busy`=0, `timeout`=0, state=IDLE, `last`=NUM_MASTERS-1, counter=0.
- Reset mid-transaction: outputs drop immediately (asynchronously). The slave is responsible for abandoning any outstanding beat.
- Grant latency: a `req` sampled high at edge k produces `grant` visible after edge k.
- Outputs are fully registered; there is no combinational path from any input to any output.
- Release: a completion handshake at edge k drops `grant` after edge k.
- Earliest re-grant is at edge k+1, so there is always exactly one idle cycle between consecutive grants.
- Grant duration is unbounded when TIMEOUT=0.
- `grant` is always zero or one-hot; `grant[grant_id]`=1 whenever `busy`=1.

## Test plan
- Single read, N=2, MODE 0:
  - Stimulus: `req`=01, `req_wr`=00 from cycle 0; `s_rvalid`=`m_rready`=1 at cycle 3.
  - Required: `grant`=01 during cycles 1..3 and `grant`=00 at cycle 4.
- Round-robin fairness, N=4:
  - Stimulus: `req`=1111 held; each grant completed 2 cycles after it is issued.
  - Required: grant sequence 0,1,2,3,0, with one idle cycle between consecutive grants.
- Fixed priority, MODE 1, N=3:
  - Stimulus: `req`=110, then `req`=111 while master 1 holds the grant.
  - Required: master 1 keeps the grant until completion; the next grant goes to master 0.
- Type isolation:
  - Stimulus: a write is granted; `s_rvalid`=`m_rready`=1 pulses, then `s_bvalid`=`m_bready`=1 arrives 5 cycles later.
  - Required: the grant is held through the read pulse and released only after the write handshake; `grant_wr`=1 throughout the grant.
- Watchdog, TIMEOUT=8:
  - Stimulus: a read is granted with no response.
  - Required: the grant drops 8 cycles after it is issued; `timeout`=1 for exactly 1 cycle; `last` advances.
  - Repeat with completion on the timeout edge: required `timeout`=0.
- Async reset:
  - Stimulus: assert `rstn`=0 mid-grant, between clock edges.
  - Required: all outputs are 0 immediately; after reset release, master 0 wins first.
